// File: rtl/comb_lock_seq.sv
// Multi-digit combination lock: digit entry with running mismatch flag, failed-attempt
// counter, sticky or timed alarm, auto-relock from OPEN and in-place combination change.
module comb_lock_seq #(
    parameter int DIGITS       = 4,
    parameter int DIGIT_W      = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_COMB = 16'h1234,
    parameter int MAX_TRIES    = 3,
    parameter int OPEN_TIMEOUT = 1000,
    parameter int ALARM_HOLD   = 0
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic [DIGIT_W-1:0]                 inps,
    input  logic                               ent,
    input  logic                               chg,
    output logic [2:0]                         state,
    output logic                               unlocked,
    output logic                               alarm,
    output logic [$clog2(DIGITS+1)-1:0]        digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
);
    localparam int DCW     = $clog2(DIGITS + 1);
    localparam int FCW     = $clog2(MAX_TRIES + 1);
    localparam int CW      = DIGITS * DIGIT_W;
    localparam int TW      = (OPEN_TIMEOUT > 0) ? $clog2(OPEN_TIMEOUT + 1) : 1;
    localparam int AW      = (ALARM_HOLD > 0) ? $clog2(ALARM_HOLD + 1) : 1;
    localparam int OT_LAST = (OPEN_TIMEOUT > 0) ? OPEN_TIMEOUT - 1 : 0;
    localparam int AH_LAST = (ALARM_HOLD > 0) ? ALARM_HOLD - 1 : 0;

    localparam logic [2:0] S_LOCKED = 3'd0;
    localparam logic [2:0] S_OPEN   = 3'd1;
    localparam logic [2:0] S_CHANGE = 3'd2;
    localparam logic [2:0] S_ALARM  = 3'd3;

    logic [2:0]     state_reg, state_next;
    logic [DCW-1:0] digit_reg, digit_next;
    logic [FCW-1:0] fail_reg, fail_next, fail_inc;
    logic           mis_reg, mis_next, mis_now;
    logic [CW-1:0]  comb_reg, comb_next;
    logic [CW-1:0]  shadow_reg, shadow_next, shadow_wr;
    logic [TW-1:0]  open_tmr_reg, open_tmr_next;
    logic [AW-1:0]  alarm_tmr_reg, alarm_tmr_next;
    logic           ent_q_reg, chg_q_reg;
    logic           epls, cpls, last_digit;

    logic [DIGITS-1:0]  sel;
    logic [DIGIT_W-1:0] comb_dig [DIGITS];
    logic [DIGIT_W-1:0] cur_digit;

    assign epls       = ent & ~ent_q_reg;
    assign cpls       = chg & ~chg_q_reg;
    assign last_digit = (digit_reg == DCW'(DIGITS - 1));
    assign fail_inc   = (fail_reg == FCW'(MAX_TRIES)) ? fail_reg : fail_reg + 1'b1;

    // Digit 0 lives in the most significant slot of the packed combination.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        localparam int LSB = (DIGITS - 1 - gi) * DIGIT_W;
        assign sel[gi]      = (digit_reg == DCW'(gi));
        assign comb_dig[gi] = sel[gi] ? comb_reg[LSB +: DIGIT_W] : '0;
        assign shadow_wr[LSB +: DIGIT_W] = sel[gi] ? inps : shadow_reg[LSB +: DIGIT_W];
    end

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) cur_digit = cur_digit | comb_dig[i];
    end

    always_comb begin
        state_next     = state_reg;
        digit_next     = digit_reg;
        fail_next      = fail_reg;
        mis_next       = mis_reg;
        comb_next      = comb_reg;
        shadow_next    = shadow_reg;
        open_tmr_next  = '0;
        alarm_tmr_next = '0;
        mis_now        = mis_reg | (inps != cur_digit);
        case (state_reg)
            S_LOCKED: begin
                if (epls) begin
                    if (last_digit) begin
                        digit_next = '0;
                        mis_next   = 1'b0;
                        if (!mis_now) begin
                            state_next = S_OPEN;
                            fail_next  = '0;
                        end else begin
                            fail_next = fail_inc;
                            if (fail_inc == FCW'(MAX_TRIES)) state_next = S_ALARM;
                        end
                    end else begin
                        digit_next = digit_reg + 1'b1;
                        mis_next   = mis_now;
                    end
                end else if (cpls) begin
                    digit_next = '0;
                    mis_next   = 1'b0;
                end
            end
            S_OPEN: begin
                if (epls) begin
                    state_next = S_LOCKED;
                end else if (cpls) begin
                    state_next = S_CHANGE;
                    digit_next = '0;
                end else if (OPEN_TIMEOUT != 0 && open_tmr_reg == TW'(OT_LAST)) begin
                    state_next = S_LOCKED;
                end else if (open_tmr_reg != '1) begin
                    open_tmr_next = open_tmr_reg + 1'b1;
                end
            end
            S_CHANGE: begin
                if (epls) begin
                    shadow_next = shadow_wr;
                    if (last_digit) begin
                        comb_next  = shadow_wr;
                        state_next = S_LOCKED;
                        digit_next = '0;
                    end else begin
                        digit_next = digit_reg + 1'b1;
                    end
                end else if (cpls) begin
                    state_next = S_OPEN;
                    digit_next = '0;
                end
            end
            S_ALARM: begin
                // Timer only runs in the timed-alarm build; sticky alarm waits for Reset.
                if (ALARM_HOLD != 0) begin
                    if (alarm_tmr_reg == AW'(AH_LAST)) begin
                        state_next = S_LOCKED;
                        fail_next  = '0;
                    end else begin
                        alarm_tmr_next = alarm_tmr_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_LOCKED;
                digit_next = '0;
                mis_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= S_LOCKED;
            digit_reg     <= '0;
            fail_reg      <= '0;
            mis_reg       <= 1'b0;
            comb_reg      <= DEFAULT_COMB;
            shadow_reg    <= '0;
            open_tmr_reg  <= '0;
            alarm_tmr_reg <= '0;
            ent_q_reg     <= 1'b1;
            chg_q_reg     <= 1'b1;
        end else begin
            state_reg     <= state_next;
            digit_reg     <= digit_next;
            fail_reg      <= fail_next;
            mis_reg       <= mis_next;
            comb_reg      <= comb_next;
            shadow_reg    <= shadow_next;
            open_tmr_reg  <= open_tmr_next;
            alarm_tmr_reg <= alarm_tmr_next;
            ent_q_reg     <= ent;
            chg_q_reg     <= chg;
        end
    end

    assign state     = state_reg;
    assign unlocked  = (state_reg == S_OPEN) || (state_reg == S_CHANGE);
    assign alarm     = (state_reg == S_ALARM);
    assign digit_cnt = digit_reg;
    assign fail_cnt  = fail_reg;
endmodule

// File: tb/tb_comb_lock_seq.sv
// Bench for comb_lock_seq: a sticky-alarm and a timed-alarm instance share all stimulus;
// a sequence-level model is compared every cycle, plus literal checkpoints.
module tb_comb_lock_seq;
    localparam int HOLD_H = 8;

    logic       Clk = 1'b0;
    logic       Reset, ent, chg;
    logic [3:0] inps;

    logic [2:0] state0, state1;
    logic       unl0, unl1, al0, al1;
    logic [2:0] dc0, dc1;
    logic [1:0] fc0, fc1;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 Clk = ~Clk;

    comb_lock_seq #(.DIGITS(4), .DIGIT_W(4), .DEFAULT_COMB(16'h1234), .MAX_TRIES(3),
                    .OPEN_TIMEOUT(20), .ALARM_HOLD(0)) dut (
        .Clk(Clk), .Reset(Reset), .inps(inps), .ent(ent), .chg(chg),
        .state(state0), .unlocked(unl0), .alarm(al0), .digit_cnt(dc0), .fail_cnt(fc0));

    comb_lock_seq #(.DIGITS(4), .DIGIT_W(4), .DEFAULT_COMB(16'h1234), .MAX_TRIES(3),
                    .OPEN_TIMEOUT(20), .ALARM_HOLD(HOLD_H)) dut_h (
        .Clk(Clk), .Reset(Reset), .inps(inps), .ent(ent), .chg(chg),
        .state(state1), .unlocked(unl1), .alarm(al1), .digit_cnt(dc1), .fail_cnt(fc1));

    // Sequence-level model: digits are collected and compared as a whole on the last one.
    int         m_st [2], m_dc [2], m_fc [2], m_idle [2], m_ast [2];
    logic [3:0] m_comb [2][4];
    logic [3:0] m_buf [2][4];
    logic       m_entq, m_chgq;
    int         m_cyc = 0;

    always @(posedge Clk) begin : model
        int st, dc, fc, idle, ast, cyc, hold;
        logic e, c, match;
        logic [3:0] cb [4];
        logic [3:0] bf [4];
        cyc = m_cyc + 1;
        e = ent && !m_entq;
        c = chg && !m_chgq;
        for (int i = 0; i < 2; i++) begin
            hold = (i == 1) ? HOLD_H : 0;
            st = m_st[i]; dc = m_dc[i]; fc = m_fc[i]; idle = m_idle[i]; ast = m_ast[i];
            for (int k = 0; k < 4; k++) begin
                cb[k] = m_comb[i][k];
                bf[k] = m_buf[i][k];
            end
            if (Reset) begin
                st = 0; dc = 0; fc = 0; idle = 0;
                for (int k = 0; k < 4; k++) cb[k] = 4'(k + 1);
            end else begin
                case (st)
                    0: begin
                        if (e) begin
                            bf[dc] = inps;
                            if (dc == 3) begin
                                match = 1'b1;
                                for (int k = 0; k < 4; k++) if (bf[k] != cb[k]) match = 1'b0;
                                dc = 0;
                                if (match) begin
                                    st = 1; fc = 0; idle = 0;
                                end else begin
                                    fc = fc + 1;
                                    if (fc == 3) begin st = 3; ast = cyc; end
                                end
                            end else begin
                                dc = dc + 1;
                            end
                        end else if (c) begin
                            dc = 0;
                        end
                    end
                    1: begin
                        if (e) st = 0;
                        else if (c) begin st = 2; dc = 0; end
                        else begin
                            idle = idle + 1;
                            if (idle == 20) st = 0;
                        end
                    end
                    2: begin
                        if (e) begin
                            bf[dc] = inps;
                            dc = dc + 1;
                            if (dc == 4) begin
                                for (int k = 0; k < 4; k++) cb[k] = bf[k];
                                dc = 0; st = 0;
                            end
                        end else if (c) begin
                            st = 1; dc = 0; idle = 0;
                        end
                    end
                    3: begin
                        if (hold != 0 && cyc - ast == hold) begin st = 0; fc = 0; end
                    end
                    default: st = 0;
                endcase
            end
            m_st[i] <= st; m_dc[i] <= dc; m_fc[i] <= fc; m_idle[i] <= idle; m_ast[i] <= ast;
            for (int k = 0; k < 4; k++) begin
                m_comb[i][k] <= cb[k];
                m_buf[i][k]  <= bf[k];
            end
        end
        m_entq <= Reset ? 1'b1 : ent;
        m_chgq <= Reset ? 1'b1 : chg;
        m_cyc  <= cyc;
    end

    function automatic logic [9:0] model_vec(input int i);
        logic u, a;
        u = (m_st[i] == 1) || (m_st[i] == 2);
        a = (m_st[i] == 3);
        return {3'(m_st[i]), u, a, 3'(m_dc[i]), 2'(m_fc[i])};
    endfunction

    always @(negedge Clk) begin : compare
        logic [9:0] act, exp;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                act = (i == 0) ? {state0, unl0, al0, dc0, fc0} : {state1, unl1, al1, dc1, fc1};
                exp = model_vec(i);
                n_assert++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL model_cmp[%0d] t=%0t got %h expected %h", i, $time, act, exp);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge Clk); inps = d; ent = 1'b1;
        @(negedge Clk); ent = 1'b0;
        $display("t=%0t ent d=%0d -> state=%0d/%0d dcnt=%0d fcnt=%0d", $time, d, state0, state1, dc0, fc0);
    endtask

    task automatic cpress();
        @(negedge Clk); chg = 1'b1;
        @(negedge Clk); chg = 1'b0;
        $display("t=%0t chg -> state=%0d/%0d dcnt=%0d fcnt=%0d", $time, state0, state1, dc0, fc0);
    endtask

    task automatic enter4(input logic [3:0] a, b, c, d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic reset_pulse();
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        $display("t=%0t reset -> state=%0d/%0d", $time, state0, state1);
    endtask

    initial begin
        Reset = 1'b1; ent = 1'b0; chg = 1'b0; inps = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk_en = 1'b1;
        check("reset_state", state0, 0);
        check("reset_digit", dc0, 0);
        check("reset_fail", fc0, 0);
        check("reset_flags", {unl0, al0}, 0);

        // Correct combination opens on the 4th press
        press(1); press(2); press(3);
        check("partial_digit_cnt", dc0, 3);
        press(4);
        check("open_state", state0, 1);
        check("open_unlocked", unl0, 1);
        check("open_digit_cnt", dc0, 0);
        press(0);
        check("ent_relocks", state0, 0);

        // Three wrong sequences: sticky vs timed alarm
        enter4(1, 2, 3, 5);
        check("fail_1", fc0, 1);
        enter4(1, 2, 3, 5);
        check("fail_2", fc0, 2);
        enter4(1, 2, 3, 5);
        check("alarm_state", state0, 3);
        check("alarm_flag", al0, 1);
        check("alarm_h_state", state1, 3);
        repeat (7) @(negedge Clk);
        check("alarm_h_held", state1, 3);
        @(negedge Clk);
        check("alarm_h_release", state1, 0);
        check("alarm_h_fail_clr", fc1, 0);
        check("alarm_sticky", state0, 3);
        enter4(1, 2, 3, 4);
        check("alarm_ignores_ent", state0, 3);
        check("alarm_ignores_digit", dc0, 0);
        check("timed_reopen", state1, 1);
        reset_pulse();
        check("alarm_reset_clears", state0, 0);

        // Change combination to 9876
        enter4(1, 2, 3, 4);
        cpress();
        check("change_state", state0, 2);
        enter4(9, 8, 7, 6);
        check("commit_locks", state0, 0);
        enter4(1, 2, 3, 4);
        check("old_comb_fails", fc0, 1);
        enter4(9, 8, 7, 6);
        check("new_comb_opens", state0, 1);
        check("new_comb_fail_clr", fc0, 0);
        reset_pulse();
        enter4(1, 2, 3, 4);
        check("reset_restores_default", state0, 1);

        // Aborted change, then idle auto-relock
        cpress(); press(9); press(8);
        check("change_digit_cnt", dc0, 2);
        cpress();
        check("abort_to_open", state0, 1);
        check("abort_digit_clr", dc0, 0);
        press(0);
        enter4(9, 8, 7, 6);
        check("abort_keeps_comb", fc0, 1);
        enter4(1, 2, 3, 4);
        check("abort_comb_opens", state0, 1);
        repeat (19) @(negedge Clk);
        check("idle_still_open", state0, 1);
        @(negedge Clk);
        check("idle_relock", state0, 0);

        // chg abandons a partial sequence in LOCKED without touching fail_cnt
        enter4(5, 5, 5, 5);
        press(1); press(2); cpress();
        check("abandon_digit", dc0, 0);
        check("abandon_keeps_fail", fc0, 1);
        enter4(1, 2, 3, 4);
        check("abandon_then_open", state0, 1);

        // ent held through reset release, then ent+chg together in OPEN
        @(negedge Clk); Reset = 1'b1; ent = 1'b1; inps = 4'd1;
        @(negedge Clk); Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("held_ent_no_capture", dc0, 0);
        ent = 1'b0;
        enter4(1, 2, 3, 4);
        @(negedge Clk); ent = 1'b1; chg = 1'b1;
        @(negedge Clk); ent = 1'b0; chg = 1'b0;
        check("ent_beats_chg", state0, 0);

        // Reset mid-entry and mid-change
        press(1); press(2);
        check("mid_entry_digit", dc0, 2);
        reset_pulse();
        check("mid_entry_reset_digit", dc0, 0);
        check("mid_entry_reset_state", state0, 0);
        enter4(1, 2, 3, 4);
        cpress(); press(9); press(8);
        reset_pulse();
        check("mid_change_reset_state", state0, 0);
        check("mid_change_reset_unl", unl0, 0);
        enter4(1, 2, 3, 4);
        check("mid_change_default_opens", state0, 1);

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
